// File: rtl/multi_port_register_file.sv
// Purpose: general-purpose register bank, one write port, two registered read ports, bulk clear.
// Latency: reads return 1 cycle after the strobe; same-edge writes are bypassed to the read data.
// Backpressure: none; while Out_Busy is high, all writes, reads and clear requests are dropped.
module multi_port_register_file #(
  parameter int P_RegWidth = 8,
  parameter int P_BitWidth = 16,
  parameter int P_ZeroReg  = 0
) (
  input  logic                          In_Clock_50MHz,
  input  logic                          In_Reset_n,
  input  logic [$clog2(P_RegWidth)-1:0] In_WriteAddress,
  input  logic [P_BitWidth-1:0]         In_WriteData,
  input  logic                          In_Write,
  input  logic [$clog2(P_RegWidth)-1:0] In_ReadAddressA,
  input  logic                          In_ReadA,
  output logic [P_BitWidth-1:0]         Out_ReadDataA,
  output logic                          Out_ValidA,
  input  logic [$clog2(P_RegWidth)-1:0] In_ReadAddressB,
  input  logic                          In_ReadB,
  output logic [P_BitWidth-1:0]         Out_ReadDataB,
  output logic                          Out_ValidB,
  input  logic                          In_Clear,
  output logic                          Out_Busy
);

  localparam int            AW        = $clog2(P_RegWidth);
  localparam logic [AW-1:0] LAST_ADDR = AW'(P_RegWidth - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [P_BitWidth-1:0] regs [P_RegWidth];

  logic                  busy;
  logic                  wr_ok;
  logic [P_BitWidth-1:0] rd_val_a, rd_val_b;

  // An address names a real, writable register: inside the depth and not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return (int'(addr) < P_RegWidth) && !((P_ZeroReg != 0) && (addr == '0));
  endfunction

  assign busy     = (state_q == S_CLEAR);
  assign Out_Busy = busy;

  // Write acceptance and read-value selection with write-first bypass.
  always_comb begin
    wr_ok    = In_Write && !busy && !In_Clear && addr_ok(In_WriteAddress);
    rd_val_a = '0;
    rd_val_b = '0;
    if (addr_ok(In_ReadAddressA)) begin
      if (wr_ok && (In_WriteAddress == In_ReadAddressA)) rd_val_a = In_WriteData;
      else                                               rd_val_a = regs[In_ReadAddressA];
    end
    if (addr_ok(In_ReadAddressB)) begin
      if (wr_ok && (In_WriteAddress == In_ReadAddressB)) rd_val_b = In_WriteData;
      else                                               rd_val_b = regs[In_ReadAddressB];
    end
  end

  // Clear sequencer next state: walk the counter 0..depth-1, then drop back to idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (In_Clear) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Clear sequencer state register; reset aborts any clear in progress.
  always_ff @(posedge In_Clock_50MHz) begin
    if (!In_Reset_n) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Register array: reset zeroes everything, clear zeroes one entry per cycle, else accepted writes.
  always_ff @(posedge In_Clock_50MHz) begin
    if (!In_Reset_n) begin
      for (int i = 0; i < P_RegWidth; i++) regs[i] <= '0;
    end else if (busy) begin
      regs[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      regs[In_WriteAddress] <= In_WriteData;
    end
  end

  // Port A output register: data updates only on a serviced read, valid is a one-cycle pulse.
  always_ff @(posedge In_Clock_50MHz) begin
    if (!In_Reset_n) begin
      Out_ReadDataA <= '0;
      Out_ValidA    <= 1'b0;
    end else if (In_ReadA && !busy) begin
      Out_ReadDataA <= rd_val_a;
      Out_ValidA    <= 1'b1;
    end else begin
      Out_ValidA    <= 1'b0;
    end
  end

  // Port B output register, independent of port A.
  always_ff @(posedge In_Clock_50MHz) begin
    if (!In_Reset_n) begin
      Out_ReadDataB <= '0;
      Out_ValidB    <= 1'b0;
    end else if (In_ReadB && !busy) begin
      Out_ReadDataB <= rd_val_b;
      Out_ValidB    <= 1'b1;
    end else begin
      Out_ValidB    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Purpose: directed bench for multi_port_register_file; three instances share one stimulus stream.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; busy windows are exercised with inputs that must be ignored.
module tb_multi_port_register_file;

  // dut 0: 8 deep, ordinary reg 0; dut 1: 8 deep, hardwired-zero reg 0; dut 2: 6 deep.
  logic        clk;
  logic        rst_n;
  logic [2:0]  wr_addr;
  logic [15:0] wr_dat;
  logic        wr_en;
  logic [2:0]  rda_addr;
  logic        rda_en;
  logic [2:0]  rdb_addr;
  logic        rdb_en;
  logic        clr;

  logic [15:0] rda_dat [3];
  logic        rda_vld [3];
  logic [15:0] rdb_dat [3];
  logic        rdb_vld [3];
  logic        busy    [3];

  int n_vec = 0;
  int n_err = 0;
  int cnt0, cnt2;

  multi_port_register_file #(.P_RegWidth(8), .P_BitWidth(16), .P_ZeroReg(0)) u_dut0 (
    .In_Clock_50MHz(clk), .In_Reset_n(rst_n),
    .In_WriteAddress(wr_addr), .In_WriteData(wr_dat), .In_Write(wr_en),
    .In_ReadAddressA(rda_addr), .In_ReadA(rda_en), .Out_ReadDataA(rda_dat[0]), .Out_ValidA(rda_vld[0]),
    .In_ReadAddressB(rdb_addr), .In_ReadB(rdb_en), .Out_ReadDataB(rdb_dat[0]), .Out_ValidB(rdb_vld[0]),
    .In_Clear(clr), .Out_Busy(busy[0])
  );

  multi_port_register_file #(.P_RegWidth(8), .P_BitWidth(16), .P_ZeroReg(1)) u_dut1 (
    .In_Clock_50MHz(clk), .In_Reset_n(rst_n),
    .In_WriteAddress(wr_addr), .In_WriteData(wr_dat), .In_Write(wr_en),
    .In_ReadAddressA(rda_addr), .In_ReadA(rda_en), .Out_ReadDataA(rda_dat[1]), .Out_ValidA(rda_vld[1]),
    .In_ReadAddressB(rdb_addr), .In_ReadB(rdb_en), .Out_ReadDataB(rdb_dat[1]), .Out_ValidB(rdb_vld[1]),
    .In_Clear(clr), .Out_Busy(busy[1])
  );

  multi_port_register_file #(.P_RegWidth(6), .P_BitWidth(16), .P_ZeroReg(0)) u_dut2 (
    .In_Clock_50MHz(clk), .In_Reset_n(rst_n),
    .In_WriteAddress(wr_addr), .In_WriteData(wr_dat), .In_Write(wr_en),
    .In_ReadAddressA(rda_addr), .In_ReadA(rda_en), .Out_ReadDataA(rda_dat[2]), .Out_ValidA(rda_vld[2]),
    .In_ReadAddressB(rdb_addr), .In_ReadB(rdb_en), .Out_ReadDataB(rdb_dat[2]), .Out_ValidB(rdb_vld[2]),
    .In_Clear(clr), .Out_Busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en  = 1'b0;
    rda_en = 1'b0;
    rdb_en = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr_addr = a;
    wr_dat  = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] aa, input logic [2:0] ab);
    rda_addr = aa;
    rdb_addr = ab;
    rda_en   = 1'b1;
    rdb_en   = 1'b1;
    tick();
    rda_en   = 1'b0;
    rdb_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_addr = '0; wr_dat = '0; rda_addr = '0; rdb_addr = '0;
    set_idle();

    // Reset state
    tick();
    tick();
    chk("rst_rda_dat", rda_dat[0], 16'h0000);
    chk("rst_rda_vld", rda_vld[0], 1'b0);
    chk("rst_rdb_vld", rdb_vld[0], 1'b0);
    chk("rst_busy",    busy[0],    1'b0);
    rst_n = 1'b1;

    // Basic write then read, valid pulses once and data holds
    do_write(3'd3, 16'h1234);
    do_read(3'd3, 3'd3);
    chk("rd3_dat",   rda_dat[0], 16'h1234);
    chk("rd3_vld",   rda_vld[0], 1'b1);
    tick();
    chk("rd3_vld_drop", rda_vld[0], 1'b0);
    chk("rd3_hold",     rda_dat[0], 16'h1234);

    // Same-edge write/read bypass on both ports
    wr_addr = 3'd5; wr_dat = 16'hBEEF; wr_en = 1'b1;
    do_read(3'd5, 3'd5);
    wr_en = 1'b0;
    chk("byp_a", rda_dat[0], 16'hBEEF);
    chk("byp_b", rdb_dat[0], 16'hBEEF);
    chk("byp_vb", rdb_vld[0], 1'b1);

    // Bypass onto hardwired zero register returns 0 and leaves reg 0 untouched
    wr_addr = 3'd0; wr_dat = 16'hBEEF; wr_en = 1'b1;
    do_read(3'd0, 3'd0);
    wr_en = 1'b0;
    chk("z0_byp_a",  rda_dat[1], 16'h0000);
    chk("z0_byp_b",  rdb_dat[1], 16'h0000);
    chk("z0_byp_va", rda_vld[1], 1'b1);
    chk("nz0_byp_a", rda_dat[0], 16'hBEEF);
    do_read(3'd0, 3'd0);
    chk("z0_after", rda_dat[1], 16'h0000);

    // Fill all addresses with 0x0011*i; addresses 6 and 7 are out of range for dut 2
    for (int i = 0; i < 8; i++) do_write(3'(i), 16'(i * 17));
    do_read(3'd7, 3'd5);
    chk("fill_r7",     rda_dat[0], 16'h0077);
    chk("oor_r7_dat",  rda_dat[2], 16'h0000);
    chk("oor_r7_vld",  rda_vld[2], 1'b1);
    chk("d2_r5",       rdb_dat[2], 16'h0055);
    chk("fill_r5",     rdb_dat[0], 16'h0055);

    // Clear with a same-cycle write to addr 2 (discarded) and a read of addr 2 (serviced)
    clr = 1'b1; wr_addr = 3'd2; wr_dat = 16'hFFFF; wr_en = 1'b1;
    rda_addr = 3'd2; rda_en = 1'b1;
    tick();
    set_idle();
    chk("clr_rd_dat", rda_dat[0], 16'h0022);
    chk("clr_rd_vld", rda_vld[0], 1'b1);

    // Count busy cycles while hammering ignored inputs during the common busy window
    cnt0 = 0;
    cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy[0]) cnt0++;
      if (busy[2]) cnt2++;
      if (i < 5) begin
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_dat = 16'hFFFF;
        rda_en = 1'b1; rdb_en = 1'b1; rda_addr = 3'd2; rdb_addr = 3'd3;
      end else begin
        set_idle();
      end
      tick();
      if (i < 5) begin
        chk("busy_vld_a", rda_vld[0], 1'b0);
        chk("busy_vld_b", rdb_vld[0], 1'b0);
      end
    end
    chk("busy_len8", cnt0, 8);
    chk("busy_len6", cnt2, 6);

    // Every register reads 0 after the clear, including addr 2
    for (int i = 0; i < 8; i += 2) begin
      do_read(3'(i), 3'(i + 1));
      chk("clr_a", rda_dat[0], 16'h0000);
      chk("clr_b", rdb_dat[0], 16'h0000);
    end

    // Reset on the third busy cycle aborts the clear
    do_write(3'd1, 16'h5A5A);
    clr = 1'b1; rda_addr = 3'd1; rda_en = 1'b1;
    tick();
    set_idle();
    chk("abort_busy1", busy[0], 1'b1);
    chk("abort_rd",    rda_dat[0], 16'h5A5A);
    tick();
    tick();
    chk("abort_busy3", busy[0], 1'b1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy0",  busy[0], 1'b0);
    chk("abort_busy2",  busy[2], 1'b0);
    chk("abort_dat_a",  rda_dat[0], 16'h0000);
    chk("abort_vld_a",  rda_vld[0], 1'b0);
    rst_n = 1'b1;
    wr_addr = 3'd4; wr_dat = 16'h4444; wr_en = 1'b1;
    do_read(3'd4, 3'd1);
    wr_en = 1'b0;
    chk("post_rst_byp", rda_dat[0], 16'h4444);
    chk("post_rst_r1",  rdb_dat[0], 16'h0000);
    do_read(3'd0, 3'd4);
    chk("post_rst_r4",  rdb_dat[0], 16'h4444);

    // Held reset blocks writes and reads
    rst_n = 1'b0;
    wr_addr = 3'd6; wr_dat = 16'h6666; wr_en = 1'b1;
    rda_addr = 3'd6; rdb_addr = 3'd6; rda_en = 1'b1; rdb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_vld_a", rda_vld[0], 1'b0);
      chk("hold_vld_b", rdb_vld[0], 1'b0);
    end
    set_idle();
    rst_n = 1'b1;
    do_read(3'd6, 3'd4);
    chk("hold_r6",     rda_dat[0], 16'h0000);
    chk("hold_r6_vld", rda_vld[0], 1'b1);
    chk("hold_r4",     rdb_dat[0], 16'h0000);

    // One-cycle reset pulse mid-stream
    do_write(3'd3, 16'h3333);
    rst_n = 1'b0;
    rda_addr = 3'd3; rda_en = 1'b1;
    tick();
    rda_en = 1'b0;
    rst_n = 1'b1;
    chk("pulse_vld", rda_vld[0], 1'b0);
    do_read(3'd3, 3'd3);
    chk("pulse_r3", rda_dat[0], 16'h0000);
    do_write(3'd3, 16'h0303);
    do_read(3'd3, 3'd3);
    chk("pulse_wr", rdb_dat[0], 16'h0303);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
